// File: rtl/enemy_tank_mover.sv
// Enemy tank motion controller: chases the upstream heading one frame tick at a time,
// spends a fixed number of ticks turning, clamps to the playfield and requests periodic shots.
module enemy_tank_mover #(
    parameter logic [10:0] START_X     = 11'd1100,
    parameter logic [9:0]  START_Y     = 10'd600,
    parameter int unsigned STEP        = 2,
    parameter logic [10:0] X_MAX       = 11'd1248,
    parameter logic [9:0]  Y_MAX       = 10'd768,
    parameter int unsigned TURN_TICKS  = 4,
    parameter int unsigned FIRE_PERIOD = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        enable,
    input  logic [1:0]  dir_in,
    output logic [10:0] blkpos_x_2,
    output logic [9:0]  blkpos_y_2,
    output logic [1:0]  facing,
    output logic        moving,
    output logic        fire
);

    localparam int unsigned XW = 11;
    localparam int unsigned YW = 10;
    localparam int unsigned TW = (TURN_TICKS > 1) ? $clog2(TURN_TICKS) : 1;
    localparam int unsigned FW = (FIRE_PERIOD > 1) ? $clog2(FIRE_PERIOD) : 1;
    localparam logic [TW-1:0] TURN_LOAD = TW'(TURN_TICKS - 1);
    localparam logic [FW-1:0] FIRE_TERM = FW'(FIRE_PERIOD - 1);
    localparam logic [XW:0]   STEP_X    = (XW + 1)'(STEP);
    localparam logic [YW:0]   STEP_Y    = (YW + 1)'(STEP);
    localparam logic [1:0]    DIR_DOWN  = 2'd0;
    localparam logic [1:0]    DIR_UP    = 2'd1;
    localparam logic [1:0]    DIR_LEFT  = 2'd2;

    typedef enum logic [1:0] {IDLE, MOVE, TURN} state_t;

    state_t         state, state_next;
    logic [TW-1:0]  turn_cnt, turn_cnt_next;
    logic [FW-1:0]  fire_cnt, fire_cnt_next;
    logic [XW-1:0]  x_next;
    logic [YW-1:0]  y_next;
    logic [1:0]     facing_next;
    logic           moving_next, fire_next;

    // Saturating one-step candidates, computed one bit wider so nothing wraps
    logic [XW:0]    x_wide, x_inc_w;
    logic [YW:0]    y_wide, y_inc_w;
    logic [XW-1:0]  x_inc, x_dec;
    logic [YW-1:0]  y_inc, y_dec;

    assign x_wide  = {1'b0, blkpos_x_2};
    assign y_wide  = {1'b0, blkpos_y_2};
    assign x_inc_w = x_wide + STEP_X;
    assign y_inc_w = y_wide + STEP_Y;
    assign x_inc   = (x_inc_w > {1'b0, X_MAX}) ? X_MAX : x_inc_w[XW-1:0];
    assign y_inc   = (y_inc_w > {1'b0, Y_MAX}) ? Y_MAX : y_inc_w[YW-1:0];
    assign x_dec   = (x_wide < STEP_X) ? '0 : XW'(x_wide - STEP_X);
    assign y_dec   = (y_wide < STEP_Y) ? '0 : YW'(y_wide - STEP_Y);

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            blkpos_x_2 <= START_X;
            blkpos_y_2 <= START_Y;
            facing     <= DIR_LEFT;
            turn_cnt   <= '0;
            fire_cnt   <= '0;
            moving     <= 1'b0;
            fire       <= 1'b0;
        end else begin
            state      <= state_next;
            blkpos_x_2 <= x_next;
            blkpos_y_2 <= y_next;
            facing     <= facing_next;
            turn_cnt   <= turn_cnt_next;
            fire_cnt   <= fire_cnt_next;
            moving     <= moving_next;
            fire       <= fire_next;
        end
    end

    // Next-state logic; a low enable overrides everything, including a coincident tick
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    state_next = MOVE;
            MOVE:    if (frame_tick && (dir_in != facing)) state_next = TURN;
            TURN:    if (frame_tick && (turn_cnt == '0))   state_next = MOVE;
            default: state_next = IDLE;
        endcase
        if (!enable) state_next = IDLE;
    end

    // Datapath and output next values
    always_comb begin
        x_next        = blkpos_x_2;
        y_next        = blkpos_y_2;
        facing_next   = facing;
        turn_cnt_next = turn_cnt;
        fire_cnt_next = fire_cnt;
        fire_next     = 1'b0;
        if (!enable) begin
            turn_cnt_next = '0;
            fire_cnt_next = '0;
        end else if (frame_tick) begin
            if (state == MOVE) begin
                if (fire_cnt == FIRE_TERM) begin
                    fire_cnt_next = '0;
                    fire_next     = 1'b1;
                end else begin
                    fire_cnt_next = fire_cnt + 1'b1;
                end
                if (dir_in == facing) begin
                    unique case (facing)
                        DIR_DOWN: y_next = y_inc;
                        DIR_UP:   y_next = y_dec;
                        DIR_LEFT: x_next = x_dec;
                        default:  x_next = x_inc;
                    endcase
                end else begin
                    facing_next   = dir_in;
                    turn_cnt_next = TURN_LOAD;
                end
            end else if (state == TURN) begin
                // Shot counter parks at terminal until a tick lands in MOVE
                if (fire_cnt != FIRE_TERM) fire_cnt_next = fire_cnt + 1'b1;
                if (turn_cnt != '0) turn_cnt_next = turn_cnt - 1'b1;
            end
        end
        moving_next = (state_next == MOVE);
    end

endmodule

// File: tb/tb_enemy_tank_mover.sv
// Scoreboard bench for enemy_tank_mover: a default instance plus one started near the
// edges so odd-offset clamping is exercised by the same stimulus.
module tb_enemy_tank_mover;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic        enable;
    logic [1:0]  dir_in;
    logic [10:0] xa, xb;
    logic [9:0]  ya, yb;
    logic [1:0]  fa, fb;
    logic        ma, mb, fire_a, fire_b;

    typedef struct {
        int          id;
        logic [10:0] xa;
        logic [9:0]  ya;
        logic [1:0]  fa;
        logic        mv;
        logic        fire;
        bit          chk_b;
        logic [10:0] xb;
        logic [9:0]  yb;
        logic [1:0]  fb;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   pulses_a = 0;
    int   pulses_b = 0;
    logic smp = 1'b0;
    logic smp_d = 1'b0;
    event now_ev;

    always #5 clk = ~clk;

    enemy_tank_mover dut_a (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .enable(enable), .dir_in(dir_in),
        .blkpos_x_2(xa), .blkpos_y_2(ya), .facing(fa), .moving(ma), .fire(fire_a)
    );

    enemy_tank_mover #(.START_X(11'd5), .START_Y(10'd765)) dut_b (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .enable(enable), .dir_in(dir_in),
        .blkpos_x_2(xb), .blkpos_y_2(yb), .facing(fb), .moving(mb), .fire(fire_b)
    );

    task automatic push(input int id, input int exa, input int eya, input int efa,
                        input logic emv, input logic efire,
                        input bit cb, input int exb, input int eyb, input int efb);
        exp_t e;
        e.id = id; e.xa = 11'(exa); e.ya = 10'(eya); e.fa = 2'(efa);
        e.mv = emv; e.fire = efire; e.chk_b = cb;
        e.xb = 11'(exb); e.yb = 10'(eyb); e.fb = 2'(efb);
        sb.push_back(e);
    endtask

    task automatic check_front();
        exp_t e;
        bit   ok;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sample_without_expectation t=%0t", $time);
        end else begin
            e  = sb.pop_front();
            ok = (xa == e.xa) && (ya == e.ya) && (fa == e.fa) && (ma == e.mv) && (fire_a == e.fire);
            if (e.chk_b)
                ok = ok && (xb == e.xb) && (yb == e.yb) && (fb == e.fb) && (mb == e.mv) && (fire_b == e.fire);
            if (!ok) begin
                errors++;
                $display("FAIL step_%0d: got a=(%0d,%0d,f%0d,m%0d,fire%0d) b=(%0d,%0d,f%0d,m%0d,fire%0d) want a=(%0d,%0d,f%0d,m%0d,fire%0d) b=(%0d,%0d,f%0d) chk_b=%0d",
                         e.id, xa, ya, fa, ma, fire_a, xb, yb, fb, mb, fire_b,
                         e.xa, e.ya, e.fa, e.mv, e.fire, e.xb, e.yb, e.fb, e.chk_b);
            end
        end
    endtask

    // Monitor: compare one cycle after every driven sample, or immediately on request
    always @(posedge clk) smp_d <= smp;
    always @(negedge clk) if (smp_d) check_front();
    always @(now_ev) check_front();

    always @(negedge clk) begin
        if (fire_a) pulses_a++;
        if (fire_b) pulses_b++;
    end

    task automatic drive(input logic ft, input logic en, input logic [1:0] d);
        @(negedge clk);
        frame_tick = ft; enable = en; dir_in = d; smp = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0; smp = 1'b0;
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; frame_tick = 1'b0; dir_in = 2'd2;
        #3;
        push(0, 1100, 600, 2, 0, 0, 1, 5, 765, 2); ->now_ev;
        #20;
        @(negedge clk) rst = 1'b0;

        // Enable: IDLE -> MOVE, nothing else changes
        push(1, 1100, 600, 2, 1, 0, 1, 5, 765, 2); drive(1'b0, 1'b1, 2'd2);

        // Ticks 1..10 heading left; b clamps from 1 to 0
        for (int k = 1; k <= 10; k++) begin
            push(10 + k, 1100 - 2 * k, 600, 2, 1, 0, 1, clamp(5 - 2 * k, 0, 2047), 765, 2);
            drive(1'b1, 1'b1, 2'd2);
        end

        // Tick 11 requests down: turn, no step
        push(111, 1080, 600, 0, 0, 0, 1, 0, 765, 0); drive(1'b1, 1'b1, 2'd0);
        for (int k = 12; k <= 15; k++) begin
            push(100 + k, 1080, 600, 0, k == 15, 0, 1, 0, 765, 0);
            drive(1'b1, 1'b1, 2'd0);
        end

        // Ticks 16..117 heading down; shot after tick 60; both clamp at 768
        for (int k = 16; k <= 117; k++) begin
            push(100 + k, 1080, clamp(600 + 2 * (k - 15), 0, 768), 0, 1, k == 60,
                 1, 0, clamp(765 + 2 * (k - 15), 0, 768), 0);
            drive(1'b1, 1'b1, 2'd0);
        end

        // Tick 118 turns right; counter reaches terminal during TURN
        push(218, 1080, 768, 3, 0, 0, 1, 0, 768, 3); drive(1'b1, 1'b1, 2'd3);
        for (int k = 119; k <= 122; k++) begin
            push(100 + k, 1080, 768, 3, k == 122, 0, 1, 0, 768, 3);
            drive(1'b1, 1'b1, 2'd3);
        end
        for (int k = 123; k <= 128; k++) begin
            push(100 + k, 1080 + 2 * (k - 122), 768, 3, 1, k == 123, 1, 2 * (k - 122), 768, 3);
            drive(1'b1, 1'b1, 2'd3);
        end

        // Enable drops together with a turning tick: nothing but the drop happens
        push(300, 1092, 768, 3, 0, 0, 1, 12, 768, 3); drive(1'b1, 1'b0, 2'd2);
        push(301, 1092, 768, 3, 1, 0, 1, 12, 768, 3); drive(1'b0, 1'b1, 2'd3);
        for (int j = 1; j <= 60; j++) begin
            push(400 + j, 1092 + 2 * j, 768, 3, 1, j == 60, 1, 12 + 2 * j, 768, 3);
            drive(1'b1, 1'b1, 2'd3);
        end

        // Enter TURN, then reset between clock edges
        push(500, 1212, 768, 2, 0, 0, 1, 132, 768, 2); drive(1'b1, 1'b1, 2'd2);
        push(501, 1212, 768, 2, 0, 0, 1, 132, 768, 2); drive(1'b1, 1'b1, 2'd2);
        @(posedge clk); #3 rst = 1'b1;
        #1 push(502, 1100, 600, 2, 0, 0, 1, 5, 765, 2); ->now_ev;
        @(posedge clk); #4
        push(503, 1100, 600, 2, 0, 0, 1, 5, 765, 2); ->now_ev;
        @(posedge clk); #3 rst = 1'b0;

        push(504, 1100, 600, 2, 1, 0, 1, 5, 765, 2); drive(1'b0, 1'b1, 2'd2);
        for (int k = 1; k <= 3; k++) begin
            push(510 + k, 1100 - 2 * k, 600, 2, 1, 0, 1, clamp(5 - 2 * k, 0, 2047), 765, 2);
            drive(1'b1, 1'b1, 2'd2);
        end
        repeat (3) @(negedge clk);

        checks++;
        if (pulses_a != 3) begin
            errors++;
            $display("FAIL fire_pulses_a: got %0d want 3", pulses_a);
        end
        checks++;
        if (pulses_b != 3) begin
            errors++;
            $display("FAIL fire_pulses_b: got %0d want 3", pulses_b);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/enemy_tank_mover.md
ENEMY_TANK_MOVER -- requirements
Module: enemy_tank_mover

Interface
REQ-001 Parameters, each as name, default, meaning:
- START_X, 11'd1100, reset x position.
- START_Y, 10'd600, reset y position.
- STEP, 2, pixels moved per frame tick.
- X_MAX, 11'd1248, largest legal x.
- Y_MAX, 10'd768, largest legal y.
- TURN_TICKS, 4, frame ticks spent turning.
- FIRE_PERIOD, 60, frame ticks between shots.
REQ-002 Ports, each as name, direction, width, meaning:
- clk, in, 1, single system clock; all state on rising edge.
- rst, in, 1, asynchronous, active-high reset.
- frame_tick, in, 1, one-clk pulse per video frame.
- enable, in, 1, game-running level.
- dir_in, in, 2, chase direction from upstream: 0 down, 1 up, 2 left, 3 right.
- blkpos_x_2, out, 11, enemy x.
- blkpos_y_2, out, 10, enemy y.
- facing, out, 2, current heading, same encoding as dir_in.
- moving, out, 1, high while the FSM is in MOVE.
- fire, out, 1, one-clk shot request.

Function
REQ-003 FSM states are IDLE, MOVE and TURN; all transitions occur on clk edges.
REQ-004 IDLE -> MOVE on the first clk with enable=1; position, facing and counters hold.
REQ-005 Any state -> IDLE on the clk after enable=0, with turn and fire counters cleared to 0 and position/facing held.
REQ-006 dir_in is sampled only on cycles with frame_tick=1; it is ignored otherwise.
REQ-007 MOVE with frame_tick=1 and dir_in==facing: step the position by STEP in facing direction (0: y+STEP, 1: y-STEP, 2: x-STEP, 3: x+STEP), registered, visible the next cycle.
REQ-008 MOVE with frame_tick=1 and dir_in!=facing: facing<=dir_in, turn counter<=TURN_TICKS-1, go to TURN, no step that tick.
REQ-009 TURN: each frame_tick decrements the turn counter; a frame_tick with counter==0 returns to MOVE without stepping; dir_in is ignored in TURN.
REQ-010 Clamp x to 0..X_MAX and y to 0..Y_MAX:
- decrement with pos<STEP yields 0;
- increment with pos+STEP>MAX yields MAX;
- arithmetic is one bit wider than the coordinate to avoid wrap.
REQ-011 A step that is fully clamped (pos already at limit) leaves position unchanged and FSM in MOVE.
REQ-012 Fire counter increments on each frame_tick while the FSM is in MOVE or TURN.
REQ-013 On reaching FIRE_PERIOD-1 the fire counter holds at terminal until a frame_tick arrives in MOVE.
REQ-014 On that frame_tick the fire counter wraps to 0 and fire is asserted high for exactly the following clk.
REQ-015 Fire counter is FIRE_PERIOD-width-safe: ceil(log2(FIRE_PERIOD)) bits minimum.
REQ-016 Simultaneous frame_tick and enable falling edge: enable takes priority; no step, no turn and no fire occur.
REQ-017 moving=1 exactly when the FSM is in MOVE; fire never asserts in IDLE.

Reset
REQ-018 rst=1 asynchronously forces all of the following:
- state IDLE;
- blkpos_x_2=START_X and blkpos_y_2=START_Y;
- facing=2;
- moving=0 and fire=0;
- turn and fire counters 0.
REQ-019 Reset asserted mid-TURN or mid-step discards the pending operation; after release the block behaves as from power-up.

Verification
REQ-020 Reset, enable=1, dir_in=2, 10 frame_ticks -> x 1100->1080, y=600, facing=2, moving=1.
REQ-021 In MOVE at facing=2, one frame_tick with dir_in=0 -> facing=0, state TURN, moving=0.
  - The next 4 frame_ticks make no position change.
  - The 5th-tick onward with dir_in=0 increments y by 2 per tick.
REQ-022 x=1 with dir_in=2 -> x=0 next tick and stays 0; y=767 with dir_in=0 -> y=768 then holds.
REQ-023 Enable held, 60 frame_ticks in MOVE -> single 1-clk fire pulse after tick 60.
  - If tick 60 falls in TURN, the pulse instead follows the first frame_tick after returning to MOVE.
REQ-024 enable dropped together with a frame_tick -> position unchanged, next cycle IDLE, fire counter 0.
  - Re-enable then yields the first fire only after a further 60 ticks.
REQ-025 rst pulsed asynchronously (between clk edges) during TURN -> outputs return immediately to reset values, with no fire pulse after release.
